// File: rtl/pcpi_arb_pkg.sv
// rtl/pcpi_arb_pkg.sv - shared types and constants for the PCPI coprocessor arbiter
package pcpi_arb_pkg;

  localparam int XLEN   = 32;
  localparam int STAT_W = 16;
  localparam int TOUT_W = $clog2(12) + 1;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    CLAIMED,
    RESPOND,
    DECLINE,
    DRAIN
  } arb_state_t;

  // Saturating increment for the statistics counters
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pcpi_arb_prio_enc.sv
// rtl/pcpi_arb_prio_enc.sv - lowest-index-wins priority encoder
module pcpi_arb_prio_enc #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/picorv32_pcpi_arbiter.sv
// rtl/picorv32_pcpi_arbiter.sv - PCPI dispatcher to NUM_COPROC coprocessors (optional stats: PCPI_ARB_STATS_EN)
module picorv32_pcpi_arbiter
  import pcpi_arb_pkg::*;
#(
  parameter int NUM_COPROC = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       pcpi_valid,
  input  logic [XLEN-1:0]            pcpi_insn,
  input  logic [XLEN-1:0]            pcpi_rs1,
  input  logic [XLEN-1:0]            pcpi_rs2,
  output logic                       pcpi_wr,
  output logic [XLEN-1:0]            pcpi_rd,
  output logic                       pcpi_wait,
  output logic                       pcpi_ready,
  output logic [NUM_COPROC-1:0]      co_valid,
  output logic [XLEN-1:0]            co_insn,
  output logic [XLEN-1:0]            co_rs1,
  output logic [XLEN-1:0]            co_rs2,
  input  logic [NUM_COPROC-1:0]      co_wr,
  input  logic [NUM_COPROC*XLEN-1:0] co_rd,
  input  logic [NUM_COPROC-1:0]      co_wait,
  input  logic [NUM_COPROC-1:0]      co_ready
`ifdef PCPI_ARB_STATS_EN
  ,
  output logic [NUM_COPROC*STAT_W-1:0] stat_done,
  output logic [STAT_W-1:0]            stat_decline
`endif
);

  localparam int IW = (NUM_COPROC > 1) ? $clog2(NUM_COPROC) : 1;
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT - 1);

  arb_state_t        state;
  logic [IW-1:0]     claim;
  logic [TOUT_W-1:0] cnt;

  logic [IW-1:0] rdy_idx;
  logic          rdy_any;
  logic [IW-1:0] wait_idx;
  logic          wait_any;

  pcpi_arb_prio_enc #(.N(NUM_COPROC), .IW(IW)) u_rdy_enc (
    .vec (co_ready),
    .idx (rdy_idx),
    .any (rdy_any)
  );

  pcpi_arb_prio_enc #(.N(NUM_COPROC), .IW(IW)) u_wait_enc (
    .vec (co_wait),
    .idx (wait_idx),
    .any (wait_any)
  );

  // Main dispatch FSM; every core- and coprocessor-facing output is registered here
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      claim      <= '0;
      cnt        <= '0;
      co_valid   <= '0;
      co_insn    <= '0;
      co_rs1     <= '0;
      co_rs2     <= '0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
    end else begin
      pcpi_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (pcpi_valid) begin
            co_insn  <= pcpi_insn;
            co_rs1   <= pcpi_rs1;
            co_rs2   <= pcpi_rs2;
            co_valid <= '1;
            cnt      <= '0;
            state    <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (!pcpi_valid) begin
            co_valid <= '0;
            state    <= IDLE;
          end else if (rdy_any) begin
            // Ready beats wait: an immediate answer needs no claim phase
            pcpi_rd    <= co_rd[XLEN*int'(rdy_idx) +: XLEN];
            pcpi_wr    <= co_wr[rdy_idx];
            pcpi_ready <= 1'b1;
            co_valid   <= '0;
            state      <= RESPOND;
          end else if (wait_any) begin
            claim     <= wait_idx;
            co_valid  <= NUM_COPROC'(1) << wait_idx;
            pcpi_wait <= 1'b1;
            state     <= CLAIMED;
          end else if (cnt == TOUT_LAST) begin
            co_valid <= '0;
            state    <= DECLINE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLAIMED: begin
          if (!pcpi_valid) begin
            co_valid  <= '0;
            pcpi_wait <= 1'b0;
            state     <= IDLE;
          end else if (co_ready[claim]) begin
            pcpi_rd    <= co_rd[XLEN*int'(claim) +: XLEN];
            pcpi_wr    <= co_wr[claim];
            pcpi_ready <= 1'b1;
            pcpi_wait  <= 1'b0;
            co_valid   <= '0;
            state      <= RESPOND;
          end
        end
        RESPOND: begin
          state <= DRAIN;
        end
        DECLINE, DRAIN: begin
          // Hold here so a still-asserted instruction is never dispatched twice
          if (!pcpi_valid) state <= IDLE;
        end
        default: begin
          co_valid  <= '0;
          pcpi_wait <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef PCPI_ARB_STATS_EN
  logic          resp_fire;
  logic [IW-1:0] resp_idx;
  logic          decline_fire;

  // Decode the FSM transitions that the statistics counters track
  always_comb begin
    resp_fire    = 1'b0;
    resp_idx     = rdy_idx;
    decline_fire = 1'b0;
    if (state == DISPATCH && pcpi_valid) begin
      resp_fire    = rdy_any;
      decline_fire = !rdy_any && !wait_any && (cnt == TOUT_LAST);
    end else if (state == CLAIMED && pcpi_valid) begin
      resp_fire = co_ready[claim];
      resp_idx  = claim;
    end
  end

  // Saturating completion and decline counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_done    <= '0;
      stat_decline <= '0;
    end else begin
      if (resp_fire)
        stat_done[STAT_W*int'(resp_idx) +: STAT_W] <=
          sat_inc(stat_done[STAT_W*int'(resp_idx) +: STAT_W]);
      if (decline_fire)
        stat_decline <= sat_inc(stat_decline);
    end
  end
`endif

endmodule

// File: tb/tb_picorv32_pcpi_arbiter.sv
// tb/tb_picorv32_pcpi_arbiter.sv - scoreboard bench for picorv32_pcpi_arbiter
module tb_picorv32_pcpi_arbiter;

  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic          pcpi_valid;
  logic [31:0]   pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic          pcpi_wr;
  logic [31:0]   pcpi_rd;
  logic          pcpi_wait, pcpi_ready;
  logic [NC-1:0] co_valid;
  logic [31:0]   co_insn, co_rs1, co_rs2;
  logic [NC-1:0] co_wr;
  logic [NC*32-1:0] co_rd;
  logic [NC-1:0] co_wait, co_ready;
`ifdef PCPI_ARB_STATS_EN
  logic [NC*16-1:0] stat_done;
  logic [15:0]      stat_decline;
`endif

  picorv32_pcpi_arbiter #(.NUM_COPROC(NC), .TIMEOUT(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready),
    .co_valid   (co_valid),
    .co_insn    (co_insn),
    .co_rs1     (co_rs1),
    .co_rs2     (co_rs2),
    .co_wr      (co_wr),
    .co_rd      (co_rd),
    .co_wait    (co_wait),
    .co_ready   (co_ready)
`ifdef PCPI_ARB_STATS_EN
    ,
    .stat_done    (stat_done),
    .stat_decline (stat_decline)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        wr;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Coprocessor behaviour: wait while age < ready_at, ready when age == ready_at (0 = never)
  bit          wait_en  [NC];
  int          ready_at [NC];
  logic [31:0] cfg_rd   [NC];
  logic        cfg_wr   [NC];
  int          age      [NC];

  int          cur_cyc, vld_cycles, wait_cycles, readies;
  logic [NC-1:0] claim_mask, vld_at_ready;
  logic [31:0] cap_insn, cap_rs1, cap_rs2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cop(input int i, input bit w, input int ra, input logic [31:0] rd, input logic wr);
    wait_en[i]  = w;
    ready_at[i] = ra;
    cfg_rd[i]   = rd;
    cfg_wr[i]   = wr;
  endtask

  task automatic clear_stats();
    vld_cycles  = 0;
    wait_cycles = 0;
    readies     = 0;
    claim_mask  = '0;
    vld_at_ready = '1;
    cur_cyc     = 0;
  endtask

  // One clock: update the coprocessor models, then observe and score the core side
  task automatic step();
    @(posedge clk);
    #1;
    cur_cyc++;
    for (int i = 0; i < NC; i++) begin
      age[i]      = co_valid[i] ? age[i] + 1 : 0;
      co_wait[i]  = wait_en[i] && co_valid[i] && (ready_at[i] == 0 || age[i] < ready_at[i]);
      co_ready[i] = co_valid[i] && ready_at[i] != 0 && age[i] == ready_at[i];
      co_wr[i]    = cfg_wr[i];
      co_rd[32*i +: 32] = cfg_rd[i];
    end
    if (cur_cyc == 1) begin
      cap_insn = co_insn;
      cap_rs1  = co_rs1;
      cap_rs2  = co_rs2;
    end
    if (co_valid != '0) vld_cycles++;
    if (pcpi_wait) begin
      wait_cycles++;
      claim_mask |= co_valid;
    end
    if (pcpi_ready) begin
      exp_t e;
      readies++;
      vld_at_ready = co_valid;
      check("sb_pending", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pcpi_rd", 64'(pcpi_rd), 64'(e.rd));
        check("pcpi_wr", 64'(pcpi_wr), 64'(e.wr));
        check("latency", 64'(cur_cyc), 64'(e.lat));
      end
    end
  endtask

  // Core side of one instruction; hold = cycles valid stays high after ready
  task automatic do_insn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                         input bit exp_rdy, input logic [31:0] e_rd, input logic e_wr,
                         input int e_lat, input int hold);
    exp_t e;
    bit   done;
    clear_stats();
    if (exp_rdy) begin
      e.rd = e_rd; e.wr = e_wr; e.lat = e_lat;
      sb.push_back(e);
    end
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = rs1;
    pcpi_rs2   = rs2;
    done = 1'b0;
    while (!done) begin
      step();
      if (readies > 0) begin
        for (int k = 0; k < hold; k++) step();
        done = 1'b1;
      end else if (!exp_rdy && cur_cyc == 14) begin
        done = 1'b1;
      end else if (cur_cyc >= 40) begin
        check("ready_timeout", 64'(readies), 64'd1);
        done = 1'b1;
      end
    end
    pcpi_valid = 1'b0;
    step();
    step();
    check("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    co_wr      = '0;
    co_rd      = '0;
    co_wait    = '0;
    co_ready   = '0;
    for (int i = 0; i < NC; i++) begin
      set_cop(i, 1'b0, 0, 32'h0, 1'b0);
      age[i] = 0;
    end
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("rst_co_valid", 64'(co_valid), 64'd0);
    check("rst_ready", 64'(pcpi_ready), 64'd0);
    check("rst_wait", 64'(pcpi_wait), 64'd0);
    check("rst_wr", 64'(pcpi_wr), 64'd0);
    check("rst_rd", 64'(pcpi_rd), 64'd0);
    check("rst_co_insn", 64'({co_insn, co_rs1 | co_rs2}), 64'd0);
    resetn = 1'b1;
    step();

    // 1: idx1 answers one cycle after co_valid
    set_cop(1, 1'b0, 2, 32'hDEADBEEF, 1'b1);
    do_insn(32'h0200_80B3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hDEADBEEF, 1'b1, 3, 0);
    check("t1_readies", 64'(readies), 64'd1);
    check("t1_wait", 64'(wait_cycles), 64'd0);
    check("t1_vld_cycles", 64'(vld_cycles), 64'd2);
    check("t1_co_insn", 64'(cap_insn), 64'h0200_80B3);
    check("t1_co_rs", 64'({cap_rs1, cap_rs2}), 64'h1234_5678_9ABC_DEF0);

    // 2: idx0 waits five cycles then answers
    set_cop(0, 1'b1, 6, 32'h0000_001B, 1'b1);
    set_cop(1, 1'b0, 0, 32'h0, 1'b0);
    do_insn(32'h0000_000B, 32'h57, 32'h83, 1'b1, 32'h0000_001B, 1'b1, 7, 0);
    check("t2_readies", 64'(readies), 64'd1);
    check("t2_wait", 64'(wait_cycles), 64'd5);
    check("t2_claim_mask", 64'(claim_mask), 64'b01);

    // 3: nobody answers -> decline after 8 dispatch cycles
    set_cop(0, 1'b0, 0, 32'h0, 1'b0);
    do_insn(32'hFFFF_FFFF, 32'h1, 32'h2, 1'b0, 32'h0, 1'b0, 0, 0);
    check("t3_readies", 64'(readies), 64'd0);
    check("t3_vld_cycles", 64'(vld_cycles), 64'd8);
    check("t3_wait", 64'(wait_cycles), 64'd0);

    // 4a: idx0 wait and idx1 ready together -> ready wins
    set_cop(0, 1'b1, 0, 32'h0BAD_0BAD, 1'b1);
    set_cop(1, 1'b0, 1, 32'h1111_2222, 1'b0);
    do_insn(32'h0000_4433, 32'h5, 32'h6, 1'b1, 32'h1111_2222, 1'b0, 2, 0);
    check("t4a_readies", 64'(readies), 64'd1);
    check("t4a_wait", 64'(wait_cycles), 64'd0);
    check("t4a_vld_at_ready", 64'(vld_at_ready), 64'd0);

    // 4b: both wait -> idx0 claimed
    set_cop(0, 1'b1, 4, 32'hA5A5_0000, 1'b1);
    set_cop(1, 1'b1, 0, 32'h0000_5555, 1'b1);
    do_insn(32'h0000_5533, 32'h7, 32'h8, 1'b1, 32'hA5A5_0000, 1'b1, 5, 0);
    check("t4b_claim_mask", 64'(claim_mask), 64'b01);
    check("t4b_wait", 64'(wait_cycles), 64'd3);

`ifdef PCPI_ARB_STATS_EN
    check("stat_done0", 64'(stat_done[15:0]), 64'd2);
    check("stat_done1", 64'(stat_done[31:16]), 64'd2);
    check("stat_decline", 64'(stat_decline), 64'd1);
`endif

    // 5a: abort while claimed
    set_cop(0, 1'b1, 0, 32'h0, 1'b0);
    set_cop(1, 1'b0, 0, 32'h0, 1'b0);
    clear_stats();
    pcpi_valid = 1'b1;
    pcpi_insn  = 32'h0000_6633;
    repeat (3) step();
    check("t5a_wait_claimed", 64'(pcpi_wait), 64'd1);
    pcpi_valid = 1'b0;
    step();
    check("t5a_abort_vld", 64'(co_valid), 64'd0);
    check("t5a_abort_wait", 64'(pcpi_wait), 64'd0);
    step();

    // 5b: async reset while dispatching
    set_cop(0, 1'b0, 0, 32'h0, 1'b0);
    pcpi_valid = 1'b1;
    pcpi_insn  = 32'h0000_7733;
    pcpi_rs1   = 32'hFEED_FACE;
    step();
    check("t5b_dispatch_vld", 64'(co_valid), 64'b11);
    resetn = 1'b0;
    #1;
    check("t5b_rst_vld", 64'(co_valid), 64'd0);
    check("t5b_rst_insn", 64'({co_insn, co_rs1}), 64'd0);
    check("t5b_rst_rd", 64'({pcpi_rd, 31'd0, pcpi_wr}), 64'd0);
    check("t5b_rst_wait", 64'({pcpi_wait, pcpi_ready}), 64'd0);
`ifdef PCPI_ARB_STATS_EN
    check("t5b_rst_stats", 64'({stat_done, stat_decline}), 64'd0);
`endif
    pcpi_valid = 1'b0;
    step();
    resetn = 1'b1;
    step();
    step();
    check("t5_no_ready", 64'(readies), 64'd0);

    // 6: valid held after ready -> no second dispatch
    set_cop(1, 1'b0, 2, 32'hCAFE_F00D, 1'b1);
    do_insn(32'h0000_8833, 32'h9, 32'hA, 1'b1, 32'hCAFE_F00D, 1'b1, 3, 4);
    check("t6_readies", 64'(readies), 64'd1);
    check("t6_vld_cycles", 64'(vld_cycles), 64'd2);
    set_cop(1, 1'b0, 2, 32'h0BAD_F00D, 1'b0);
    do_insn(32'h0000_9933, 32'hB, 32'hC, 1'b1, 32'h0BAD_F00D, 1'b0, 3, 0);
    check("t6_next_readies", 64'(readies), 64'd1);
    check("t6_next_insn", 64'(cap_insn), 64'h0000_9933);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
